// File: rtl/spi_reg_writer_if.sv
// Request handshake and SPI pin bundle for spi_reg_writer.
// master = request source / SPI observer, slave = spi_reg_writer.
interface spi_reg_writer_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, sclk, copi, ncs, busy, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, sclk, copi, ncs, busy, done, err
    );
endinterface

// File: rtl/spi_reg_writer.sv
// Write-only SPI mode-0 controller sending {1'b1, addr[6:0], data[7:0]} frames, MSB first.
// Optional: define SPI_REG_WRITER_ADDR_CHECK_EN to reject requests with req_addr > MAX_ADDR.
module spi_reg_writer #(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [6:0]  MAX_ADDR = 7'h04
) (
    input logic              clk,
    input logic              rst,
    spi_reg_writer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HI,
        SCLK_LO,
        HOLD,
        GAP
    } state_t;

    localparam logic [8:0] DIV = 9'(CLK_DIV);

    state_t      state;
    state_t      state_next;
    logic [8:0]  cnt;
    logic [8:0]  phase_len;
    logic        phase_end;
    logic [3:0]  bit_cnt;
    logic [15:0] shreg;
    logic        done_q;
    logic        accept;
    logic        bad_addr;

    assign accept = bus.req_valid && (state == IDLE);

`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
    logic err_q;
    assign bad_addr = (bus.req_addr > MAX_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && bad_addr;
        end
    end
`else
    assign bad_addr = 1'b0;
`endif

    // HOLD covers the trailing sclk-low phase plus the ncs hold time; GAP is one
    // cycle short because the following IDLE cycle completes the ncs-high gap.
    always_comb begin
        phase_len = DIV;
        case (state)
            HOLD:    phase_len = DIV << 1;
            GAP:     phase_len = DIV - 9'd1;
            default: phase_len = DIV;
        endcase
    end

    assign phase_end = (cnt == phase_len - 9'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !bad_addr) state_next = SETUP;
            SETUP:   if (phase_end) state_next = SCLK_HI;
            SCLK_HI: if (phase_end) state_next = (bit_cnt == 4'd15) ? HOLD : SCLK_LO;
            SCLK_LO: if (phase_end) state_next = SCLK_HI;
            HOLD:    if (phase_end) state_next = GAP;
            GAP:     if (phase_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == GAP) && phase_end;
            if (state_next != state) begin
                cnt <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + 9'd1;
            end
            if (accept && !bad_addr) begin
                shreg   <= {1'b1, bus.req_addr, bus.req_data};
                bit_cnt <= '0;
            end else if (state == SCLK_HI && phase_end) begin
                shreg   <= {shreg[14:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.busy      = (state != IDLE);
        bus.sclk      = (state == SCLK_HI);
        bus.ncs       = !(state == SETUP || state == SCLK_HI ||
                          state == SCLK_LO || state == HOLD);
        bus.copi      = !bus.ncs && shreg[15];
        bus.done      = done_q;
`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
        bus.err       = err_q;
`else
        bus.err       = 1'b0;
`endif
    end
endmodule

// File: tb/tb_spi_reg_writer.sv
// Self-checking bench for spi_reg_writer: directed and random frames against a frame/timing model.
module tb_spi_reg_writer;
    logic clk;
    logic rst;
    logic v4;
    logic v2;
    logic sel;
    logic [6:0] addr;
    logic [7:0] data;
    int checks;
    int errors;

    spi_reg_writer_if b4 ();
    spi_reg_writer_if b2 ();

    assign b4.req_valid = v4;
    assign b4.req_addr  = addr;
    assign b4.req_data  = data;
    assign b2.req_valid = v2;
    assign b2.req_addr  = addr;
    assign b2.req_data  = data;

    spi_reg_writer #(.CLK_DIV(4), .MAX_ADDR(7'h04)) u4 (.clk(clk), .rst(rst), .bus(b4));
    spi_reg_writer #(.CLK_DIV(2), .MAX_ADDR(7'h7F)) u2 (.clk(clk), .rst(rst), .bus(b2));

    logic m_sclk, m_copi, m_ncs, m_busy, m_done, m_err, m_ready;
    assign m_sclk  = sel ? b2.sclk      : b4.sclk;
    assign m_copi  = sel ? b2.copi      : b4.copi;
    assign m_ncs   = sel ? b2.ncs       : b4.ncs;
    assign m_busy  = sel ? b2.busy      : b4.busy;
    assign m_done  = sel ? b2.done      : b4.done;
    assign m_err   = sel ? b2.err       : b4.err;
    assign m_ready = sel ? b2.req_ready : b4.req_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raises req_valid so the request is accepted at the next rising edge.
    task automatic issue(input bit use2, input logic [6:0] a, input logic [7:0] d, input bit keep);
        @(posedge clk); #1;
        addr = a;
        data = d;
        if (use2) v2 = 1'b1; else v4 = 1'b1;
        @(negedge clk);
        check("ready_before_accept", {31'd0, m_ready}, 32'd1);
        @(posedge clk); #1;
        if (!keep) begin
            v2 = 1'b0;
            v4 = 1'b0;
        end
    endtask

    // Observes one frame starting at cycle T+1 until done or a cycle budget.
    task automatic monitor(input int div, input bit perturb, output logic [15:0] bits,
                           output int rises, output int low, output int done_at,
                           output int gap, output int bad);
        logic prev_sclk;
        logic prev_copi;
        logic hi_seen;
        int   run;
        int   last_low;
        bits = '0; rises = 0; low = 0; done_at = 0; gap = 0; bad = 0;
        prev_sclk = 1'b0; prev_copi = 1'b0; hi_seen = 1'b0; run = 0; last_low = 0;
        for (int n = 1; n <= 40 * div; n++) begin
            @(negedge clk);
            if (m_sclk && !prev_sclk) begin
                bits = {bits[14:0], m_copi};
                rises++;
            end
            if (m_sclk && prev_sclk && (m_copi !== prev_copi)) bad++;
            if (m_sclk != prev_sclk) begin
                if (prev_sclk && run != div) bad++;
                if (!prev_sclk && hi_seen && run != div) bad++;
                if (m_sclk) hi_seen = 1'b1;
                run = 0;
            end
            run++;
            prev_sclk = m_sclk;
            prev_copi = m_copi;
            if (!m_ncs) begin
                low++;
                last_low = n;
            end
            if (m_ncs && m_copi) bad++;
            if (m_err) bad++;
            if (m_done) begin
                if (!m_ready || m_busy) bad++;
                done_at = n;
                gap = n - last_low;
                break;
            end
            if (m_ready || !m_busy) bad++;
            if (perturb) begin
                addr = 7'($urandom);
                data = 8'($urandom);
            end
        end
    endtask

    task automatic frame_check(input string tag, input int div, input logic [15:0] exp_bits,
                               input logic [15:0] bits, input int rises, input int low,
                               input int done_at, input int gap, input int bad);
        check({tag, "_bits"}, {16'd0, bits}, {16'd0, exp_bits});
        check({tag, "_rises"}, rises, 16);
        check({tag, "_ncs_low"}, low, 34 * div);
        check({tag, "_done_at"}, done_at, 35 * div);
        check({tag, "_gap"}, gap, div);
        check({tag, "_protocol"}, bad, 0);
    endtask

    initial begin
        logic [15:0] bits;
        int rises, low, done_at, gap, bad;
        logic [6:0] ra;
        logic [7:0] rd;
        logic prev;

        checks = 0; errors = 0;
        v4 = 1'b0; v2 = 1'b0; sel = 1'b0; addr = '0; data = '0;
        rst = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_ncs", {31'd0, m_ncs}, 32'd1);
        check("rst_sclk", {31'd0, m_sclk}, 32'd0);
        check("rst_copi", {31'd0, m_copi}, 32'd0);
        check("rst_busy_done_err", {29'd0, m_busy, m_done, m_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, m_ready}, 32'd1);

        issue(0, 7'h02, 8'hA5, 0);
        monitor(4, 0, bits, rises, low, done_at, gap, bad);
        frame_check("basic", 4, 16'h82A5, bits, rises, low, done_at, gap, bad);

        for (int i = 0; i < 4; i++) begin
`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
            ra = 7'($urandom_range(0, 4));
`else
            ra = 7'($urandom);
`endif
            rd = 8'($urandom);
            issue(0, ra, rd, 0);
            monitor(4, 1, bits, rises, low, done_at, gap, bad);
            frame_check("random", 4, {1'b1, ra, rd}, bits, rises, low, done_at, gap, bad);
        end

        issue(0, 7'h00, 8'hFF, 1);
        addr = 7'h01;
        data = 8'h0F;
        monitor(4, 0, bits, rises, low, done_at, gap, bad);
        frame_check("b2b_first", 4, 16'h80FF, bits, rises, low, done_at, gap, bad);
        @(posedge clk); #1;
        v4 = 1'b0;
        monitor(4, 0, bits, rises, low, done_at, gap, bad);
        frame_check("b2b_second", 4, 16'h810F, bits, rises, low, done_at, gap, bad);

        issue(0, 7'h03, 8'h3C, 0);
        rises = 0;
        prev = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (m_sclk && !prev) rises++;
            prev = m_sclk;
            if (rises == 7) break;
        end
        check("abort_reach_edge7", rises, 7);
        rst = 1'b1;
        #1;
        check("abort_ncs", {31'd0, m_ncs}, 32'd1);
        check("abort_sclk", {31'd0, m_sclk}, 32'd0);
        check("abort_busy", {31'd0, m_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3 * 35 * 4; n++) begin
            @(negedge clk);
            if (m_done) break;
        end
        check("abort_no_done", {31'd0, m_done}, 32'd0);
        issue(0, 7'h55, 8'h96, 0);
        monitor(4, 0, bits, rises, low, done_at, gap, bad);
        frame_check("after_abort", 4, 16'hD596, bits, rises, low, done_at, gap, bad);

`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
        issue(0, 7'h05, 8'h11, 0);
        @(negedge clk);
        check("reject_err_pulse", {31'd0, m_err}, 32'd1);
        check("reject_ncs", {31'd0, m_ncs}, 32'd1);
        check("reject_ready", {31'd0, m_ready}, 32'd1);
        bad = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (m_err || !m_ncs || m_busy) bad++;
        end
        check("reject_stay_idle", bad, 0);
        issue(0, 7'h04, 8'h22, 0);
        monitor(4, 0, bits, rises, low, done_at, gap, bad);
        frame_check("max_addr", 4, 16'h8422, bits, rises, low, done_at, gap, bad);
`else
        issue(0, 7'h7F, 8'h11, 0);
        monitor(4, 0, bits, rises, low, done_at, gap, bad);
        frame_check("high_addr", 4, 16'hFF11, bits, rises, low, done_at, gap, bad);
`endif

        sel = 1'b1;
        @(negedge clk);
        issue(1, 7'h7F, 8'h00, 0);
        monitor(2, 0, bits, rises, low, done_at, gap, bad);
        frame_check("div2", 2, 16'hFF00, bits, rises, low, done_at, gap, bad);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
